tcdm_xbar_rr: RTL and testbench
===============================

# tcdm_xbar_rr

Parametrised logarithmic crossbar between NumIn core-side initiators and NumOut single-ported TCDM banks, with fair per-bank round-robin arbitration, configurable bank interleaving and a pipelined response return matched to any bank read latency. It sits between the cluster cores/DMA ports and the bank array as the next-generation full-crossbar option of the TCDM interconnect family.

## Interface
- NumIn, 8, initiator ports; power of 2, at least 2
- NumOut, 16, TCDM banks; power of 2, at least 2
- AddrWidth, 32, initiator byte-address width
- DataWidth, 32, word width; power of 2, at least 8
- BeWidth, DataWidth/8, byte enables per word
- AddrMemWidth, 12, word-address bits per bank
- InterleaveWords, 1, consecutive words mapped to one bank; power of 2
- MemLatency, 1, bank read latency in cycles; at least 1
- WriteRespOn, 1, 1: writes return vld_o; 0: writes are silent
- CntWidth, 16, conflict-counter width (only with TCDM_XBAR_STATS_EN)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NumIn  request
- add_i  in  NumIn x AddrWidth  byte address
- wen_i  in  NumIn  1 store, 0 load
- wdata_i  in  NumIn x DataWidth  write data
- be_i  in  NumIn x BeWidth  byte enables
- gnt_o  out  NumIn  grant, combinational on req_i/add_i/gnt_i
- vld_o  out  NumIn  response valid
- rdata_o  out  NumIn x DataWidth  read data
- req_o  out  NumOut  bank request
- gnt_i  in  NumOut  bank ready
- add_o  out  NumOut x AddrMemWidth  bank word address
- wen_o  out  NumOut  store
- wdata_o  out  NumOut x DataWidth  write data
- be_o  out  NumOut x BeWidth  byte enables
- rdata_i  in  NumOut x DataWidth  bank read data
- conflict_cnt_o  out  NumOut x CntWidth  per-bank conflict count (only with TCDM_XBAR_STATS_EN)

## Operation
- WordOff = log2(DataWidth/8), IlW = log2(InterleaveWords), BankW = log2(NumOut).
- Bank index = add_i[WordOff+IlW+BankW-1 : WordOff+IlW]; bank word address = {add_i[WordOff+IlW+BankW+AddrMemWidth-IlW-1 : WordOff+IlW+BankW], add_i[WordOff+IlW-1 : WordOff]}.
- Per bank: round-robin pointer rr_q (log2(NumIn) bits). Winner = first requesting initiator at index >= rr_q, wrapping. req_o = any requester; add/wen/wdata/be muxed from winner; all-zero when no requester.
- gnt_o[j] = j is winner of its bank AND gnt_i[bank]. Losers see gnt_o=0 and must hold.
- Handshake (req_o & gnt_i) sets rr_q = winner+1 mod NumIn; otherwise rr_q holds (bank stall does not rotate priority).
- Response pipeline per bank: MemLatency-deep shift register of {valid, initiator index}. Entry valid on handshake when load, or store with WriteRespOn=1.
- Pipeline output valid -> vld_o[idx]=1, rdata_o[idx]=rdata_i[bank]. No collisions: an initiator is granted by at most one bank per cycle. rdata_o='0 when vld_o=0.

## Timing
- Request path fully combinational: zero cycles to req_o/gnt_o.
- vld_o exactly MemLatency cycles after the grant cycle, one cycle wide; full throughput of one request per bank per cycle, responses in grant order.
- Reset: rr_q=0, shift registers cleared, vld_o=0, rdata_o='0, conflict_cnt_o=0; combinational outputs follow inputs. Reset mid-operation drops in-flight responses.

## Configuration
- TCDM_XBAR_STATS_EN defined: conflict_cnt_o present; per-bank counter increments by 1 each cycle with 2 or more requesters on that bank, saturating at all-ones.
- Undefined: port and counters absent; no other change.

## Structure
- Package tcdm_xbar_pkg: width helpers (WordOff, BankW, IlW functions), response-pipeline entry struct.
- Sub-module tcdm_bank_arb: one per bank, holds rr_q, winner select, request mux and response shift register.
- Elaboration assertions on power-of-2 parameters, MemLatency>=1, and address width sufficient for mapping.

## Test plan
- Reset held then released, requests idle -> vld_o=0, req_o=0, conflict_cnt_o=0.
- NumIn=4, NumOut=8, MemLatency=1: initiator 2 loads 0x14 -> req_o[5]=1, add_o[5]=0, gnt_o[2]=1 same cycle; next cycle vld_o[2]=1, rdata_o[2]=rdata_i[5].
- Initiators 0,1,3 hold requests to bank 0, gnt_i=1 -> grant order 0,1,3,0,1,3; with macro, counter reaches 6 after 6 cycles.
- gnt_i[3]=0 for 3 cycles with two requesters -> req_o[3]=1, no gnt_o, no vld; on release the same winner is granted first.
- Store with WriteRespOn=0 -> no vld_o; WriteRespOn=1 -> vld_o after MemLatency.
- MemLatency=3, InterleaveWords=4: loads to 0x0,0x4,0x8,0xC back-to-back -> all to bank 0, add_o 0..3, vld_o on cycles 3..6 in order.

Source files
------------

// File: rtl/tcdm_xbar_pkg.sv
// Shared helpers and types for the tcdm_xbar_rr crossbar.
// The optional statistics feature is enabled with TCDM_XBAR_STATS_EN.
package tcdm_xbar_pkg;

  localparam int unsigned MaxIdxW = 8;

  function automatic int unsigned word_off(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int unsigned il_w(input int unsigned interleave_words);
    return $clog2(interleave_words);
  endfunction

  function automatic int unsigned bank_w(input int unsigned num_out);
    return $clog2(num_out);
  endfunction

  function automatic bit is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

  typedef struct packed {
    logic               vld;
    logic [MaxIdxW-1:0] idx;
  } resp_entry_t;

endpackage

// File: rtl/tcdm_xbar_rr_bank_arb.sv
// tcdm_bank_arb: per-bank round-robin arbiter, request mux and response pipeline.
// The conflict counter exists only when TCDM_XBAR_STATS_EN is defined.
module tcdm_bank_arb
  import tcdm_xbar_pkg::*;
#(
  parameter int unsigned NumIn        = 8,
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned MemLatency   = 1,
  parameter int unsigned WriteRespOn  = 1,
  parameter int unsigned CntWidth     = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [NumIn-1:0]                    i_req,
  input  logic [NumIn-1:0][AddrMemWidth-1:0]  i_add,
  input  logic [NumIn-1:0]                    i_wen,
  input  logic [NumIn-1:0][DataWidth-1:0]     i_wdata,
  input  logic [NumIn-1:0][BeWidth-1:0]       i_be,
  input  logic                                i_gnt,
  output logic [NumIn-1:0]                    o_gnt,
  output logic                                o_req,
  output logic [AddrMemWidth-1:0]             o_add,
  output logic                                o_wen,
  output logic [DataWidth-1:0]                o_wdata,
  output logic [BeWidth-1:0]                  o_be,
  output logic                                o_resp_vld,
  output logic [MaxIdxW-1:0]                  o_resp_idx
`ifdef TCDM_XBAR_STATS_EN
  ,
  output logic [CntWidth-1:0]                 o_conflict_cnt
`endif
);

  localparam int unsigned InW = $clog2(NumIn);

  logic [InW-1:0]             r_rr;
  resp_entry_t [MemLatency-1:0] r_pipe;

  logic [InW-1:0] w_cand;
  logic [InW-1:0] w_winner;
  logic           w_found;
  logic           w_hs;
  resp_entry_t    w_entry;

  // First requester at or after the pointer, wrapping modulo NumIn.
  always_comb begin
    w_cand   = '0;
    w_winner = '0;
    w_found  = 1'b0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      w_cand = r_rr + InW'(k);
      if (!w_found && i_req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_comb begin
    o_req   = w_found;
    o_add   = '0;
    o_wen   = 1'b0;
    o_wdata = '0;
    o_be    = '0;
    o_gnt   = '0;
    if (w_found) begin
      o_add   = i_add[w_winner];
      o_wen   = i_wen[w_winner];
      o_wdata = i_wdata[w_winner];
      o_be    = i_be[w_winner];
      if (i_gnt) o_gnt[w_winner] = 1'b1;
    end
  end

  assign w_hs = w_found && i_gnt;

  always_comb begin
    w_entry     = '0;
    w_entry.vld = w_hs && (!i_wen[w_winner] || (WriteRespOn != 0));
    w_entry.idx = MaxIdxW'(w_winner);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr   <= '0;
      r_pipe <= '0;
    end else begin
      if (w_hs) r_rr <= w_winner + InW'(1);
      for (int unsigned i = 1; i < MemLatency; i++) r_pipe[i] <= r_pipe[i-1];
      r_pipe[0] <= w_entry;
    end
  end

  assign o_resp_vld = r_pipe[MemLatency-1].vld;
  assign o_resp_idx = r_pipe[MemLatency-1].idx;

`ifdef TCDM_XBAR_STATS_EN
  logic [CntWidth-1:0] r_cnt;
  logic                w_conflict;

  // Two or more bits set: clearing the lowest set bit leaves something.
  assign w_conflict = (i_req & (i_req - NumIn'(1))) != '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_conflict && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CntWidth'(1);
    end
  end

  assign o_conflict_cnt = r_cnt;
`endif

endmodule

// File: rtl/tcdm_xbar_rr.sv
// Logarithmic NumIn x NumOut TCDM crossbar with per-bank round-robin arbitration.
// Per-bank conflict counters are added when TCDM_XBAR_STATS_EN is defined.
module tcdm_xbar_rr
  import tcdm_xbar_pkg::*;
#(
  parameter int unsigned NumIn           = 8,
  parameter int unsigned NumOut          = 16,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned DataWidth       = 32,
  parameter int unsigned BeWidth         = DataWidth / 8,
  parameter int unsigned AddrMemWidth    = 12,
  parameter int unsigned InterleaveWords = 1,
  parameter int unsigned MemLatency      = 1,
  parameter int unsigned WriteRespOn     = 1,
  parameter int unsigned CntWidth        = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumIn-1:0]                     req_i,
  input  logic [NumIn-1:0][AddrWidth-1:0]      add_i,
  input  logic [NumIn-1:0]                     wen_i,
  input  logic [NumIn-1:0][DataWidth-1:0]      wdata_i,
  input  logic [NumIn-1:0][BeWidth-1:0]        be_i,
  output logic [NumIn-1:0]                     gnt_o,
  output logic [NumIn-1:0]                     vld_o,
  output logic [NumIn-1:0][DataWidth-1:0]      rdata_o,
  output logic [NumOut-1:0]                    req_o,
  input  logic [NumOut-1:0]                    gnt_i,
  output logic [NumOut-1:0][AddrMemWidth-1:0]  add_o,
  output logic [NumOut-1:0]                    wen_o,
  output logic [NumOut-1:0][DataWidth-1:0]     wdata_o,
  output logic [NumOut-1:0][BeWidth-1:0]       be_o,
  input  logic [NumOut-1:0][DataWidth-1:0]     rdata_i
`ifdef TCDM_XBAR_STATS_EN
  ,
  output logic [NumOut-1:0][CntWidth-1:0]      conflict_cnt_o
`endif
);

  localparam int unsigned WordOff = word_off(DataWidth);
  localparam int unsigned IlW     = il_w(InterleaveWords);
  localparam int unsigned BankW   = bank_w(NumOut);
  localparam int unsigned BankLsb = WordOff + IlW;
  localparam int unsigned HiLsb   = BankLsb + BankW;

  if (!is_pow2(NumIn) || NumIn < 2 || NumIn > (1 << MaxIdxW)) begin : g_err_num_in
    $error("NumIn must be a power of 2, at least 2");
  end
  if (!is_pow2(NumOut) || NumOut < 2) begin : g_err_num_out
    $error("NumOut must be a power of 2, at least 2");
  end
  if (!is_pow2(DataWidth) || DataWidth < 8) begin : g_err_data_width
    $error("DataWidth must be a power of 2, at least 8");
  end
  if (!is_pow2(InterleaveWords)) begin : g_err_interleave
    $error("InterleaveWords must be a power of 2");
  end
  if (MemLatency < 1) begin : g_err_latency
    $error("MemLatency must be at least 1");
  end
  if (AddrMemWidth <= IlW || AddrWidth < HiLsb + AddrMemWidth - IlW) begin : g_err_addr
    $error("AddrWidth too small for the bank mapping");
  end

  logic [NumIn-1:0][BankW-1:0]             w_bank_sel;
  logic [NumIn-1:0][AddrMemWidth-1:0]      w_word_add;
  logic [NumOut-1:0][NumIn-1:0]            w_bank_req;
  logic [NumOut-1:0][NumIn-1:0]            w_bank_gnt;
  logic [NumOut-1:0]                       w_resp_vld;
  logic [NumOut-1:0][MaxIdxW-1:0]          w_resp_idx;
  logic                                    w_unused;

  // Byte-offset and upper address bits play no part in the mapping.
  assign w_unused = ^add_i;

  for (genvar j = 0; j < NumIn; j++) begin : g_map
    assign w_bank_sel[j] = add_i[j][HiLsb-1:BankLsb];
    if (IlW == 0) begin : g_flat
      assign w_word_add[j] = add_i[j][HiLsb+AddrMemWidth-1:HiLsb];
    end else begin : g_il
      assign w_word_add[j] = {add_i[j][HiLsb+AddrMemWidth-IlW-1:HiLsb],
                              add_i[j][BankLsb-1:WordOff]};
    end
  end

  always_comb begin
    w_bank_req = '0;
    for (int unsigned b = 0; b < NumOut; b++) begin
      for (int unsigned j = 0; j < NumIn; j++) begin
        w_bank_req[b][j] = req_i[j] && (w_bank_sel[j] == BankW'(b));
      end
    end
  end

  for (genvar b = 0; b < NumOut; b++) begin : g_bank
    tcdm_bank_arb #(
      .NumIn        (NumIn),
      .AddrMemWidth (AddrMemWidth),
      .DataWidth    (DataWidth),
      .BeWidth      (BeWidth),
      .MemLatency   (MemLatency),
      .WriteRespOn  (WriteRespOn),
      .CntWidth     (CntWidth)
    ) u_arb (
      .i_clk          (clk_i),
      .i_rst_n        (rst_ni),
      .i_req          (w_bank_req[b]),
      .i_add          (w_word_add),
      .i_wen          (wen_i),
      .i_wdata        (wdata_i),
      .i_be           (be_i),
      .i_gnt          (gnt_i[b]),
      .o_gnt          (w_bank_gnt[b]),
      .o_req          (req_o[b]),
      .o_add          (add_o[b]),
      .o_wen          (wen_o[b]),
      .o_wdata        (wdata_o[b]),
      .o_be           (be_o[b]),
      .o_resp_vld     (w_resp_vld[b]),
      .o_resp_idx     (w_resp_idx[b])
`ifdef TCDM_XBAR_STATS_EN
      ,
      .o_conflict_cnt (conflict_cnt_o[b])
`endif
    );
  end

  always_comb begin
    gnt_o = '0;
    for (int unsigned b = 0; b < NumOut; b++) gnt_o = gnt_o | w_bank_gnt[b];
  end

  // Each initiator is granted by at most one bank per cycle, so OR-merging is collision free.
  always_comb begin
    vld_o   = '0;
    rdata_o = '0;
    for (int unsigned j = 0; j < NumIn; j++) begin
      for (int unsigned b = 0; b < NumOut; b++) begin
        if (w_resp_vld[b] && (w_resp_idx[b] == MaxIdxW'(j))) begin
          vld_o[j]   = 1'b1;
          rdata_o[j] = rdata_o[j] | rdata_i[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_tcdm_xbar_rr.sv
// Directed self-checking bench for tcdm_xbar_rr; honours TCDM_XBAR_STATS_EN when defined.
module tb_tcdm_xbar_rr;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shared stimulus for instances A (WriteRespOn=1) and B (WriteRespOn=0)
  logic [3:0]        req;
  logic [3:0][31:0]  add;
  logic [3:0]        wen;
  logic [3:0][31:0]  wdata;
  logic [3:0][3:0]   be;
  logic [7:0]        gnt_i;
  logic [7:0][31:0]  rdata_i;

  logic [3:0]        gnt_a, vld_a, gnt_b, vld_b;
  logic [3:0][31:0]  rdata_a, rdata_b;
  logic [7:0]        req_o_a, wen_o_a, req_o_b, wen_o_b;
  logic [7:0][11:0]  add_o_a, add_o_b;
  logic [7:0][31:0]  wdata_o_a, wdata_o_b;
  logic [7:0][3:0]   be_o_a, be_o_b;
  logic [7:0][15:0]  cnt_a, cnt_b, cnt_c;

  // Instance C: MemLatency=3, InterleaveWords=4
  logic [3:0]        req_c, wen_c;
  logic [3:0][31:0]  add_c, wdata_c;
  logic [3:0][3:0]   be_c;
  logic [7:0]        gnt_i_c;
  logic [7:0][31:0]  rdata_i_c;
  logic [3:0]        gnt_c, vld_c;
  logic [3:0][31:0]  rdata_c;
  logic [7:0]        req_o_c, wen_o_c;
  logic [7:0][11:0]  add_o_c;
  logic [7:0][31:0]  wdata_o_c;
  logic [7:0][3:0]   be_o_c;

  tcdm_xbar_rr #(.NumIn(4), .NumOut(8), .MemLatency(1), .WriteRespOn(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt_a), .vld_o(vld_a), .rdata_o(rdata_a),
    .req_o(req_o_a), .gnt_i(gnt_i), .add_o(add_o_a), .wen_o(wen_o_a),
    .wdata_o(wdata_o_a), .be_o(be_o_a), .rdata_i(rdata_i)
`ifdef TCDM_XBAR_STATS_EN
    , .conflict_cnt_o(cnt_a)
`endif
  );

  tcdm_xbar_rr #(.NumIn(4), .NumOut(8), .MemLatency(1), .WriteRespOn(0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt_b), .vld_o(vld_b), .rdata_o(rdata_b),
    .req_o(req_o_b), .gnt_i(gnt_i), .add_o(add_o_b), .wen_o(wen_o_b),
    .wdata_o(wdata_o_b), .be_o(be_o_b), .rdata_i(rdata_i)
`ifdef TCDM_XBAR_STATS_EN
    , .conflict_cnt_o(cnt_b)
`endif
  );

  tcdm_xbar_rr #(.NumIn(4), .NumOut(8), .MemLatency(3), .InterleaveWords(4), .WriteRespOn(1)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_c), .add_i(add_c), .wen_i(wen_c),
    .wdata_i(wdata_c), .be_i(be_c), .gnt_o(gnt_c), .vld_o(vld_c), .rdata_o(rdata_c),
    .req_o(req_o_c), .gnt_i(gnt_i_c), .add_o(add_o_c), .wen_o(wen_o_c),
    .wdata_o(wdata_o_c), .be_o(be_o_c), .rdata_i(rdata_i_c)
`ifdef TCDM_XBAR_STATS_EN
    , .conflict_cnt_o(cnt_c)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (vld_a !== 4'b0) begin errors++; $display("FAIL reset_vld_a: got %b expected 0000", vld_a); end
    checks++; if (req_o_a !== 8'h00) begin errors++; $display("FAIL reset_req_o: got %h expected 00", req_o_a); end
    checks++; if (rdata_a !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata_a); end
    checks++; if (vld_c !== 4'b0) begin errors++; $display("FAIL reset_vld_c: got %b expected 0000", vld_c); end
`ifdef TCDM_XBAR_STATS_EN
    checks++; if (cnt_a !== '0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", cnt_a); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (vld_a !== 4'b0 || req_o_a !== 8'h00) begin
      errors++; $display("FAIL idle_after_reset: got vld %b req_o %h expected 0000 00", vld_a, req_o_a);
    end
  endtask

  task automatic test_single_load();
    req = 4'b0100; add[2] = 32'h14; wen = '0;
    #1;
    checks++; if (req_o_a !== 8'b0010_0000) begin errors++; $display("FAIL load_req_o: got %b expected 00100000", req_o_a); end
    checks++; if (add_o_a[5] !== 12'h0) begin errors++; $display("FAIL load_add_o: got %h expected 000", add_o_a[5]); end
    checks++; if (gnt_a !== 4'b0100) begin errors++; $display("FAIL load_gnt: got %b expected 0100", gnt_a); end
    @(negedge clk);
    req = 4'b0010; add[1] = 32'hA4;
    #1;
    checks++; if (vld_a !== 4'b0100) begin errors++; $display("FAIL load_vld: got %b expected 0100", vld_a); end
    checks++; if (rdata_a[2] !== 32'hA000_0005 || rdata_a[0] !== '0) begin
      errors++; $display("FAIL load_rdata: got %h/%h expected a0000005/00000000", rdata_a[2], rdata_a[0]);
    end
    checks++; if (req_o_a !== 8'h02 || add_o_a[1] !== 12'h5) begin
      errors++; $display("FAIL map_bank1: got req_o %h add %h expected 02 005", req_o_a, add_o_a[1]);
    end
    @(negedge clk);
    req = '0;
    #1;
    checks++; if (vld_a !== 4'b0010 || rdata_a[1] !== 32'hA000_0001) begin
      errors++; $display("FAIL map_bank1_resp: got %b %h expected 0010 a0000001", vld_a, rdata_a[1]);
    end
    @(negedge clk);
    checks++; if (vld_a !== 4'b0) begin errors++; $display("FAIL vld_one_cycle: got %b expected 0000", vld_a); end
  endtask

  task automatic test_rr_order();
    logic [3:0] exp_g [3];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000;
    req = 4'b1011; add[0] = '0; add[1] = '0; add[3] = '0; wen = '0;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (gnt_a !== exp_g[k % 3]) begin
        errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt_a, exp_g[k % 3]);
      end
      if (k > 0) begin
        checks++; if (vld_a !== exp_g[(k - 1) % 3]) begin
          errors++; $display("FAIL rr_vld[%0d]: got %b expected %b", k, vld_a, exp_g[(k - 1) % 3]);
        end
      end
      @(negedge clk);
    end
`ifdef TCDM_XBAR_STATS_EN
    checks++; if (cnt_a[0] !== 16'd6) begin errors++; $display("FAIL conflict_cnt: got %0d expected 6", cnt_a[0]); end
`endif
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall();
    gnt_i = 8'hF7; req = 4'b0011; add[0] = 32'hC; add[1] = 32'hC; wen = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_o_a !== 8'h08 || gnt_a !== 4'b0 || vld_a !== 4'b0) begin
        errors++; $display("FAIL stall[%0d]: got req_o %h gnt %b vld %b expected 08 0000 0000", k, req_o_a, gnt_a, vld_a);
      end
      @(negedge clk);
    end
    gnt_i = '1;
    #1;
    checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL stall_release: got %b expected 0001", gnt_a); end
    @(negedge clk);
    #1;
    checks++; if (gnt_a !== 4'b0010 || vld_a !== 4'b0001) begin
      errors++; $display("FAIL stall_next: got gnt %b vld %b expected 0010 0001", gnt_a, vld_a);
    end
    @(negedge clk);
    req = '0;
    #1;
    checks++; if (vld_a !== 4'b0010) begin errors++; $display("FAIL stall_resp2: got %b expected 0010", vld_a); end
    @(negedge clk);
  endtask

  task automatic test_store();
    req = 4'b0001; add[0] = 32'h8; wen = 4'b0001; wdata[0] = 32'hDEAD_BEEF; be[0] = 4'b0110;
    #1;
    checks++; if (wen_o_a[2] !== 1'b1 || wdata_o_a[2] !== 32'hDEAD_BEEF || be_o_a[2] !== 4'b0110) begin
      errors++; $display("FAIL store_mux: got wen %b wdata %h be %b expected 1 deadbeef 0110", wen_o_a[2], wdata_o_a[2], be_o_a[2]);
    end
    checks++; if (gnt_a !== 4'b0001 || gnt_b !== 4'b0001) begin
      errors++; $display("FAIL store_gnt: got %b/%b expected 0001/0001", gnt_a, gnt_b);
    end
    @(negedge clk);
    req = '0; wen = '0;
    #1;
    checks++; if (vld_a !== 4'b0001) begin errors++; $display("FAIL store_resp_on: got %b expected 0001", vld_a); end
    checks++; if (vld_b !== 4'b0000 || rdata_b !== '0) begin
      errors++; $display("FAIL store_resp_off: got %b %h expected 0000 0", vld_b, rdata_b);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_v;
    logic [31:0] exp_d;
    wen_c = '0; gnt_i_c = '1;
    for (int k = 0; k < 8; k++) begin
      req_c = (k < 4) ? 4'b0001 : 4'b0000;
      add_c[0] = 32'(k * 4);
      rdata_i_c[0] = 32'hC0 + 32'(k);
      #1;
      if (k < 4) begin
        checks++; if (gnt_c !== 4'b0001 || req_o_c !== 8'h01 || add_o_c[0] !== 12'(k)) begin
          errors++; $display("FAIL b2b_req[%0d]: got gnt %b req_o %h add %h expected 0001 01 %h", k, gnt_c, req_o_c, add_o_c[0], 12'(k));
        end
      end
      exp_v = (k >= 3 && k <= 6) ? 4'b0001 : 4'b0000;
      exp_d = (k >= 3 && k <= 6) ? 32'hC0 + 32'(k) : 32'h0;
      checks++; if (vld_c !== exp_v || rdata_c[0] !== exp_d) begin
        errors++; $display("FAIL b2b_resp[%0d]: got vld %b rdata %h expected %b %h", k, vld_c, rdata_c[0], exp_v, exp_d);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_flush();
    req = 4'b1000; add[3] = '0; wen = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    checks++; if (vld_a !== 4'b0 || rdata_a !== '0) begin
      errors++; $display("FAIL reset_flush: got vld %b rdata %h expected 0000 0", vld_a, rdata_a);
    end
`ifdef TCDM_XBAR_STATS_EN
    checks++; if (cnt_a[0] !== 16'd0) begin errors++; $display("FAIL reset_cnt_clear: got %0d expected 0", cnt_a[0]); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    req = '0; add = '0; wen = '0; wdata = '0; be = '0; gnt_i = '1;
    for (int b = 0; b < 8; b++) rdata_i[b] = 32'hA000_0000 + 32'(b);
    req_c = '0; add_c = '0; wen_c = '0; wdata_c = '0; be_c = '0; gnt_i_c = '1; rdata_i_c = '0;
    test_reset();
    test_single_load();
    test_rr_order();
    test_stall();
    test_store();
    test_back_to_back();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
